// File: rtl/fpu_cmd_issuer_pkg.sv
// Shared types and constants for the FPU command issuer.
package fpu_cmd_issuer_pkg;

  localparam logic [5:0]  OP_LI_INT    = 6'b111001;
  localparam logic [5:0]  OP_LI_FLT    = 6'b111110;
  localparam logic [5:0]  OP_BIN       = 6'b000001;
  localparam logic [5:0]  OP_READ      = 6'b111000;

  // Result word reported when the watchdog aborts a command.
  localparam logic [31:0] TIMEOUT_DATA = 32'hdeadbeef;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
  } fpu_cmd_t;

  typedef struct packed {
    logic [31:0] data32;
    logic        data1;
    logic        err;
  } fpu_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

endpackage

// File: rtl/fpu_cmd_issuer_if.sv
// Command, response and FPU request bundle of the issuer.
// master: the issuer itself. slave: the core plus the FPU around it.
interface fpu_cmd_issuer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_op;
  logic [4:0]  cmd_x1;
  logic [4:0]  cmd_x2;
  logic [4:0]  cmd_y;
  logic [31:0] cmd_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data32;
  logic        rsp_data1;
  logic        rsp_err;

  logic        fpu_ready;
  logic [5:0]  fpu_operation;
  logic [4:0]  fpu_x1;
  logic [4:0]  fpu_x2;
  logic [4:0]  fpu_y;
  logic [31:0] fpu_in_data;
  logic        fpu_valid;
  logic [31:0] fpu_out_data32;
  logic        fpu_out_data1;

  modport master (
    input  cmd_valid, cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data32, rsp_data1, rsp_err,
    input  rsp_ready,
    output fpu_ready, fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data,
    input  fpu_valid, fpu_out_data32, fpu_out_data1
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_x1, cmd_x2, cmd_y, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data32, rsp_data1, rsp_err,
    output rsp_ready,
    input  fpu_ready, fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data,
    output fpu_valid, fpu_out_data32, fpu_out_data1
  );

endinterface

// File: rtl/fpu_cmd_issuer_fifo.sv
// Synchronous command FIFO with occupancy count. No bypass: a full FIFO
// refuses pushes even in a cycle where it is being popped.
module fpu_cmd_issuer_fifo
  import fpu_cmd_issuer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  fpu_cmd_t wr_data_i,
  input  logic     pop_i,
  output fpu_cmd_t rd_data_o,
  output logic     full_o,
  output logic     empty_o,
  output logic [AW:0] count_o
);

  fpu_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// FPU command issuer: buffers core commands and drives them one at a time
// onto the FPU request bus, returning each result to the core in order.
// Optional watchdog on the FPU handshake: define FPU_CMD_ISSUER_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no command at the FPU; pops the FIFO head when one is present
//   ISSUE | fpu_ready high, fields frozen, waiting for fpu_valid
//   RESP  | result held on rsp_* until the core takes it
module fpu_cmd_issuer
  import fpu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  fpu_cmd_issuer_if.master       bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fpu_cmd_issuer: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fpu_cmd_issuer: TIMEOUT_CYCLES must be >= 1");
  end

  fpu_cmd_t push_cmd;
  fpu_cmd_t head_cmd;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;

  state_e   state_q,     state_d;
  fpu_cmd_t cmd_q,       cmd_d;
  logic     fpu_ready_q, fpu_ready_d;
  logic     rsp_valid_q, rsp_valid_d;
  fpu_rsp_t rsp_q,       rsp_d;

`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  assign push_cmd = {bus.cmd_op, bus.cmd_x1, bus.cmd_x2, bus.cmd_y, bus.cmd_data};

  fpu_cmd_issuer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (bus.cmd_valid),
    .wr_data_i (push_cmd),
    .pop_i     (pop),
    .rd_data_o (head_cmd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign bus.cmd_ready     = !fifo_full;
  assign bus.fpu_ready     = fpu_ready_q;
  assign bus.fpu_operation = cmd_q.op;
  assign bus.fpu_x1        = cmd_q.x1;
  assign bus.fpu_x2        = cmd_q.x2;
  assign bus.fpu_y         = cmd_q.y;
  assign bus.fpu_in_data   = cmd_q.data;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data32    = rsp_q.data32;
  assign bus.rsp_data1     = rsp_q.data1;
  assign bus.rsp_err       = rsp_q.err;
  assign busy              = (state_q != IDLE) || !fifo_empty;

  // State and output registers; reset clears fpu_ready without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      fpu_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      fpu_ready_q <= fpu_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    fpu_ready_d = fpu_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    pop         = 1'b0;
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          cmd_d       = head_cmd;
          fpu_ready_d = 1'b1;
          state_d     = ISSUE;
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      ISSUE: begin
        // A valid on the same edge as the timeout counts as a normal completion.
        if (bus.fpu_valid) begin
          rsp_d.data32 = bus.fpu_out_data32;
          rsp_d.data1  = bus.fpu_out_data1;
          rsp_d.err    = 1'b0;
          fpu_ready_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          rsp_d.data32 = TIMEOUT_DATA;
          rsp_d.data1  = 1'b0;
          rsp_d.err    = 1'b1;
          fpu_ready_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
module tb_fpu_cmd_issuer;
  import fpu_cmd_issuer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic [$clog2(DEPTH):0] fifo_count;
  int checks = 0;
  int failures = 0;

  fpu_cmd_issuer_if bus();

  fpu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // FPU model: valid for one cycle on the 3rd cycle of ready, then waits for ready to drop.
  logic        m_valid = 1'b0;
  logic [31:0] m_d32 = '0;
  logic        m_d1 = 1'b0;
  logic [1:0]  m_cnt = '0;
  logic [31:0] fregs [0:31];
  logic        model_mute = 1'b0;
  logic        inj_valid = 1'b0;

  assign bus.fpu_valid      = m_valid | inj_valid;
  assign bus.fpu_out_data32 = m_d32;
  assign bus.fpu_out_data1  = m_d1;

  always @(posedge clk) begin
    if (!bus.fpu_ready) begin
      m_cnt   <= '0;
      m_valid <= 1'b0;
    end else if (m_cnt < 2'd2) begin
      m_cnt <= m_cnt + 2'd1;
    end else if (m_cnt == 2'd2 && !model_mute) begin
      m_cnt   <= 2'd3;
      m_valid <= 1'b1;
      case (bus.fpu_operation)
        OP_LI_INT, OP_LI_FLT: begin
          fregs[bus.fpu_y] <= bus.fpu_in_data;
          m_d32 <= bus.fpu_in_data;
          m_d1  <= 1'b0;
        end
        OP_BIN: begin
          fregs[bus.fpu_y] <= fregs[bus.fpu_x1] + fregs[bus.fpu_x2];
          m_d32 <= fregs[bus.fpu_x1] + fregs[bus.fpu_x2];
          m_d1  <= 1'b0;
        end
        OP_READ: begin
          m_d32 <= fregs[bus.fpu_x1];
          m_d1  <= 1'b1;
        end
        default: begin
          m_d32 <= '0;
          m_d1  <= 1'b0;
        end
      endcase
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Response collector: {err, data1, data32}
  logic [33:0] rsp_q [$];
  always @(posedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready)
      rsp_q.push_back({bus.rsp_err, bus.rsp_data1, bus.rsp_data32});
  end

  // Request-bus monitor: gap between ready pulses, field stability, pulse length.
  int          run_len = 0;
  int          gap_len = 0;
  int          min_gap = 1000;
  int          last_run = 0;
  bit          seen_run = 0;
  bit          stab_err = 0;
  logic        prev_rdy = 1'b0;
  logic [52:0] prev_fields = '0;
  logic [52:0] cur_fields;
  assign cur_fields = {bus.fpu_operation, bus.fpu_x1, bus.fpu_x2, bus.fpu_y, bus.fpu_in_data};

  always @(posedge clk) begin
    if (bus.fpu_ready) begin
      if (prev_rdy) begin
        if (cur_fields != prev_fields) stab_err = 1;
        run_len++;
      end else begin
        if (seen_run && gap_len < min_gap) min_gap = gap_len;
        run_len = 1;
      end
      seen_run = 1;
      gap_len  = 0;
    end else begin
      if (prev_rdy) last_run = run_len;
      gap_len++;
    end
    prev_rdy    = bus.fpu_ready;
    prev_fields = cur_fields;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout sim time limit reached");
    $fatal(1, "simulation time limit");
  end

  task automatic push_cmd(input logic [5:0] op, input logic [4:0] x1, input logic [4:0] x2,
                          input logic [4:0] y, input logic [31:0] data);
    int n = 0;
    bus.cmd_op = op; bus.cmd_x1 = x1; bus.cmd_x2 = x2; bus.cmd_y = y; bus.cmd_data = data;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL push_stall got cmd_ready=%b want 1 within 200 cycles", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int n);
    int t = 0;
    while (rsp_q.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (rsp_q.size() < n) begin
      failures++;
      $display("FAIL rsp_wait got=%0d responses want=%0d", rsp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.fpu_ready !== 1'b0) begin failures++; $display("FAIL reset_fpu_ready got=%b want=0", bus.fpu_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b want=0", bus.rsp_err); end
    checks++; if (bus.rsp_data32 !== 32'd0) begin failures++; $display("FAIL reset_rsp_data32 got=%h want=0", bus.rsp_data32); end
    checks++; if (bus.fpu_operation !== 6'd0) begin failures++; $display("FAIL reset_fpu_op got=%h want=0", bus.fpu_operation); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d want=0", fifo_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_li_pair();
    rsp_q.delete();
    bus.rsp_ready = 1'b1;
    push_cmd(OP_LI_INT, 5'd0, 5'd0, 5'd0, 32'd43);
    push_cmd(OP_LI_INT, 5'd0, 5'd0, 5'd1, 32'd14);
    wait_rsps(2);
    repeat (4) @(negedge clk);
    checks++; if (rsp_q.size() !== 2) begin failures++; $display("FAIL li_count got=%0d want=2", rsp_q.size()); end
    if (rsp_q.size() >= 2) begin
      checks++; if (rsp_q[0] !== {1'b0, 1'b0, 32'd43}) begin failures++; $display("FAIL li_rsp0 got=%h want=%h", rsp_q[0], {1'b0, 1'b0, 32'd43}); end
      checks++; if (rsp_q[1] !== {1'b0, 1'b0, 32'd14}) begin failures++; $display("FAIL li_rsp1 got=%h want=%h", rsp_q[1], {1'b0, 1'b0, 32'd14}); end
    end
  endtask

  task automatic test_bin_read();
    rsp_q.delete();
    push_cmd(OP_BIN, 5'd1, 5'd0, 5'd2, 32'd0);
    push_cmd(OP_READ, 5'd2, 5'd0, 5'd0, 32'd0);
    wait_rsps(2);
    repeat (4) @(negedge clk);
    checks++; if (rsp_q.size() !== 2) begin failures++; $display("FAIL bin_count got=%0d want=2", rsp_q.size()); end
    if (rsp_q.size() >= 2) begin
      checks++; if (rsp_q[0] !== {1'b0, 1'b0, 32'd57}) begin failures++; $display("FAIL bin_rsp got=%h want=%h", rsp_q[0], {1'b0, 1'b0, 32'd57}); end
      checks++; if (rsp_q[1] !== {1'b0, 1'b1, 32'd57}) begin failures++; $display("FAIL read_rsp got=%h want=%h", rsp_q[1], {1'b0, 1'b1, 32'd57}); end
    end
    checks++; if (stab_err !== 1'b0) begin failures++; $display("FAIL field_stability got=%b want=0", stab_err); end
  endtask

  task automatic test_back_to_back();
    rsp_q.delete();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(OP_LI_INT, 5'd0, 5'd0, 5'(3 + i), 32'(100 + i));
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL full_cmd_ready got=%b want=0", bus.cmd_ready); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d want=4", fifo_count); end
    repeat (10) @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL held_rsp_valid got=%b want=1", bus.rsp_valid); end
    checks++; if (bus.rsp_data32 !== 32'd100) begin failures++; $display("FAIL held_rsp_data got=%0d want=100", bus.rsp_data32); end
    checks++; if (fifo_count !== 3'd4 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL held_full got count=%0d ready=%b want 4/0", fifo_count, bus.cmd_ready); end
    bus.rsp_ready = 1'b1;
    wait_rsps(5);
    repeat (6) @(negedge clk);
    checks++; if (rsp_q.size() !== 5) begin failures++; $display("FAIL b2b_count got=%0d want=5", rsp_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < rsp_q.size()) begin
        checks++;
        if (rsp_q[i] !== {1'b0, 1'b0, 32'(100 + i)}) begin
          failures++; $display("FAIL b2b_rsp%0d got=%h want=%h", i, rsp_q[i], {1'b0, 1'b0, 32'(100 + i)});
        end
      end
    end
    checks++; if (bus.cmd_ready !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL drained got ready=%b count=%0d busy=%b want 1/0/0", bus.cmd_ready, fifo_count, busy);
    end
  endtask

  task automatic test_reset_mid_issue();
    rsp_q.delete();
    bus.rsp_ready = 1'b1;
    push_cmd(OP_LI_FLT, 5'd0, 5'd0, 5'd2, 32'hc0490fcf);
    checks++; if (bus.fpu_ready !== 1'b0 || fifo_count !== 3'd1) begin
      failures++; $display("FAIL start_pre got ready=%b count=%0d want 0/1", bus.fpu_ready, fifo_count);
    end
    @(negedge clk);
    checks++; if (bus.fpu_ready !== 1'b1 || fifo_count !== 3'd0) begin
      failures++; $display("FAIL start_issue got ready=%b count=%0d want 1/0", bus.fpu_ready, fifo_count);
    end
    checks++; if (bus.fpu_operation !== OP_LI_FLT || bus.fpu_y !== 5'd2 || bus.fpu_in_data !== 32'hc0490fcf) begin
      failures++; $display("FAIL issue_fields got op=%b y=%0d data=%h want %b/2/c0490fcf", bus.fpu_operation, bus.fpu_y, bus.fpu_in_data, OP_LI_FLT);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.fpu_ready !== 1'b0) begin failures++; $display("FAIL async_drop got=%b want=0", bus.fpu_ready); end
    checks++; if (fifo_count !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_state got count=%0d busy=%b want 0/0", fifo_count, busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (rsp_q.size() !== 0 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_no_rsp got n=%0d rsp_valid=%b want 0/0", rsp_q.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_spurious_valid();
    int t = 0;
    rsp_q.delete();
    bus.rsp_ready = 1'b1;
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_q.size() !== 0) begin
      failures++; $display("FAIL idle_valid got rsp_valid=%b busy=%b n=%0d want 0/0/0", bus.rsp_valid, busy, rsp_q.size());
    end
    bus.rsp_ready = 1'b0;
    push_cmd(OP_LI_INT, 5'd0, 5'd0, 5'd8, 32'h000000aa);
    while (!bus.rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    inj_valid = 1'b1;
    repeat (2) @(negedge clk);
    inj_valid = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data32 !== 32'haa || bus.fpu_ready !== 1'b0) begin
      failures++; $display("FAIL resp_valid_ignored got v=%b d=%h r=%b want 1/aa/0", bus.rsp_valid, bus.rsp_data32, bus.fpu_ready);
    end
    bus.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rsp_q.size() !== 1) begin failures++; $display("FAIL spurious_count got=%0d want=1", rsp_q.size()); end
    checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL spurious_end got v=%b busy=%b want 0/0", bus.rsp_valid, busy);
    end
  endtask

`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
  task automatic test_timeout();
    int t = 0;
    rsp_q.delete();
    bus.rsp_ready = 1'b1;
    model_mute = 1'b1;
    push_cmd(OP_LI_INT, 5'd0, 5'd0, 5'd9, 32'h11);
    push_cmd(OP_LI_INT, 5'd0, 5'd0, 5'd10, 32'h22);
    while (!bus.rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    model_mute = 1'b0;
    @(negedge clk);
    checks++; if (last_run !== 16) begin failures++; $display("FAIL timeout_len got=%0d want=16", last_run); end
    wait_rsps(2);
    if (rsp_q.size() >= 2) begin
      checks++; if (rsp_q[0] !== {1'b1, 1'b0, 32'hdeadbeef}) begin failures++; $display("FAIL timeout_rsp got=%h want=%h", rsp_q[0], {1'b1, 1'b0, 32'hdeadbeef}); end
      checks++; if (rsp_q[1] !== {1'b0, 1'b0, 32'h22}) begin failures++; $display("FAIL after_timeout got=%h want=%h", rsp_q[1], {1'b0, 1'b0, 32'h22}); end
    end
  endtask
`endif

  task automatic test_handshake_rules();
    checks++; if (min_gap < 2) begin failures++; $display("FAIL ready_gap got=%0d want>=2", min_gap); end
    checks++; if (stab_err !== 1'b0) begin failures++; $display("FAIL final_stability got=%b want=0", stab_err); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0; bus.cmd_x1 = '0; bus.cmd_x2 = '0; bus.cmd_y = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_li_pair();
    test_bin_read();
    test_back_to_back();
    test_reset_mid_issue();
    test_spurious_valid();
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
    test_timeout();
`endif
    test_handshake_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
